id_exe_elastic_stage: RTL and testbench
=======================================

Name: id_exe_elastic_stage

Overview:
Parametrised, handshaked ID→EXE pipeline register replacing the fixed always-advance stage register. It carries a generic data payload and a control field, plus rs/rt/waddr tags for forwarding. It adds valid/ready flow control with an optional skid entry, a synchronous flush, and built-in load-use hazard detection. When the stage is empty the control field is forced to zero, so a bubble never writes registers or memory.

Parameters:
DATA_W, 64, payload width (operands, immediate, nPC), passed through unmodified
CTRL_W, 7, control-bit width (aluop, wen, memwrite, memread, memtoreg, jal); zeroed on bubble/flush
ASIZE, 4, register-address width for waddr/rs/rt
MEMREAD_BIT, 4, index of the memread bit inside the ctrl field
SKID, 1, 1 = two-entry skid buffer (in_ready registered); 0 = single entry (in_ready = !out_valid || out_ready)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  squash all held entries (branch/jump taken)
in_valid  in  1  ID presents an instruction
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  payload
in_ctrl  in  CTRL_W  control bits
in_waddr  in  ASIZE  destination register
in_rs  in  ASIZE  source register 1 tag
in_rt  in  ASIZE  source register 2 tag
out_valid  out  1  EXE entry valid
out_ready  in  1  EXE consumes entry this cycle
out_data  out  DATA_W  registered payload
out_ctrl  out  CTRL_W  registered control; 0 whenever out_valid=0
out_waddr  out  ASIZE  registered destination
out_rs  out  ASIZE  registered rs tag for forwarding unit
out_rt  out  ASIZE  registered rt tag for forwarding unit
load_use_stall  out  1  hazard indication to IF/ID (hold PC and IF/ID)

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_ctrl=0, out_waddr=0, out_rs=0, out_rt=0, skid entry invalid. in_ready=0 and load_use_stall=0 while rst=1.
- Priority: rst > flush > normal operation.
- Accept: acc = in_valid && in_ready. Issue: iss = out_valid && out_ready.
- Hazard (combinational): haz = out_valid && out_ctrl[MEMREAD_BIT] && out_waddr!=0 && in_valid && (out_waddr==in_rs || out_waddr==in_rt). load_use_stall = haz. in_ready is gated by !haz and !flush.
- SKID=0: in_ready = !out_valid || out_ready (gated). On acc, the main entry loads in_*. On iss without acc: out_valid→0 and out_ctrl→0; out_data, tags and waddr hold.
- SKID=1: in_ready = !skid_valid (gated).
  - Main empty or iss: main loads from skid if skid_valid, else from input if acc, else becomes empty (ctrl zeroed).
  - Main full, no iss, acc: skid captures input.
  - Main loads from skid while acc in the same cycle: skid captures input.
- Latency: 1 cycle from acc to out_valid with an empty stage. Order is strictly FIFO; no entry is ever dropped or duplicated except by flush.
- Hazard resolution: while haz, the input is not accepted. Once the load issues, the stage empties, which yields exactly one bubble (out_valid=0, out_ctrl=0). The dependent instruction is accepted the following cycle.
- Flush: at the next posedge, main and skid become invalid and out_ctrl=0. No input is accepted in a flush cycle. An iss in the same cycle still counts as consumed by EXE.
- Reset mid-stream discards all entries; no partial state survives.
- waddr=0 never raises a hazard (r0).

Test Plan:
- Reset then idle: rst 2 cycles, in_valid=0 → all outputs 0, in_ready=1 from first cycle after rst deasserts.
- Streaming (SKID=1, out_ready=1): 8 back-to-back instructions data=0x1..0x8 → out_valid continuous from cycle 1, out_data 0x1..0x8 in order, in_ready never drops.
- Backpressure: hold out_ready=0 for 3 cycles while in_valid=1 → main holds 0x1, skid takes 0x2, in_ready=0 next cycle. Release → 0x2 then 0x3 issue, no loss or duplication.
- Load-use: EXE entry memread=1, waddr=5; ID in_rs=5 → load_use_stall=1, in_ready=0. Next cycle one bubble with out_ctrl=0, then the dependent instruction issues. Repeat with waddr=0 → no stall.
- Flush with full skid: main 0xA, skid 0xB, flush=1 with in_valid=1 → next cycle out_valid=0, out_ctrl=0, input 0xC not accepted (in_ready=0 that cycle).
- SKID=0 build: same streaming and backpressure sequences → identical order. in_ready tracks out_ready combinationally when full.

Source files
------------

// File: rtl/id_exe_elastic_stage.sv
// ---------------------------------------------------------------------------
// id_exe_elastic_stage
//
// Handshaked ID->EXE pipeline register. It carries a generic payload, a
// control field and the rs/rt/waddr tags that the forwarding unit needs.
// The stage also detects load-use hazards between the instruction it holds
// and the one that ID is presenting.
//
// The stage is built in one of two ways:
//   SKID=1 : main entry plus one skid entry. in_ready_o depends only on
//            registered state, apart from the hazard/flush/reset gating.
//   SKID=0 : main entry only. in_ready_o = !out_valid || out_ready.
// The control field is cleared whenever the main entry is empty. A bubble
// therefore never writes the register file or memory.
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   rst_i            synchronous, active-high reset
//   flush_i          squash every held entry (branch/jump taken)
//   in_valid_i       ID presents an instruction
//   in_ready_o       stage accepts this cycle
//   in_data_i        payload (operands, immediate, nPC)
//   in_ctrl_i        control bits
//   in_waddr_i       destination register
//   in_rs_i/in_rt_i  source register tags
//   out_valid_o      EXE entry valid
//   out_ready_i      EXE consumes the entry this cycle
//   out_data_o       registered payload
//   out_ctrl_o       registered control; zero whenever out_valid_o=0
//   out_waddr_o      registered destination
//   out_rs_o/out_rt_o registered source tags
//   load_use_stall_o hold PC and IF/ID because of a load-use hazard
// ---------------------------------------------------------------------------
module id_exe_elastic_stage #(
    parameter int DATA_W      = 64,
    parameter int CTRL_W      = 7,
    parameter int ASIZE       = 4,
    parameter int MEMREAD_BIT = 4,
    parameter int SKID        = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [ASIZE-1:0]  in_waddr_i,
    input  logic [ASIZE-1:0]  in_rs_i,
    input  logic [ASIZE-1:0]  in_rt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [ASIZE-1:0]  out_waddr_o,
    output logic [ASIZE-1:0]  out_rs_o,
    output logic [ASIZE-1:0]  out_rt_o,
    output logic              load_use_stall_o
);

    // An entry is stored packed as {data, ctrl, waddr, rs, rt}.
    localparam int  EW       = DATA_W + CTRL_W + 3 * ASIZE;
    localparam int  RT_LSB   = 0;
    localparam int  RS_LSB   = ASIZE;
    localparam int  WA_LSB   = 2 * ASIZE;
    localparam int  CT_LSB   = 3 * ASIZE;
    localparam int  DA_LSB   = 3 * ASIZE + CTRL_W;
    localparam bit  USE_SKID = (SKID != 0);
    // Clearing these bits turns an entry into a bubble. The payload and the
    // tags keep their values.
    localparam logic [EW-1:0] CTRL_MASK =
        {{DATA_W{1'b0}}, {CTRL_W{1'b1}}, {(3 * ASIZE){1'b0}}};

    logic              main_valid_q, main_valid_d;
    logic [EW-1:0]     main_q, main_d;
    logic              skid_valid_q, skid_valid_d;
    logic [EW-1:0]     skid_q, skid_d;

    logic [EW-1:0]     in_ent_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [ASIZE-1:0]  main_waddr_s;
    logic              haz_s;
    logic              base_ready_s;
    logic              in_ready_s;
    logic              acc_s;
    logic              iss_s;

    assign in_ent_s     = {in_data_i, in_ctrl_i, in_waddr_i, in_rs_i, in_rt_i};
    assign main_ctrl_s  = main_q[CT_LSB +: CTRL_W];
    assign main_waddr_s = main_q[WA_LSB +: ASIZE];

    // Load-use hazard: the held load targets a non-zero register that the incoming instruction reads.
    always_comb begin
        haz_s = 1'b0;
        if (main_valid_q && main_ctrl_s[MEMREAD_BIT] &&
            (main_waddr_s != {ASIZE{1'b0}}) && in_valid_i &&
            ((main_waddr_s == in_rs_i) || (main_waddr_s == in_rt_i))) begin
            haz_s = 1'b1;
        end else begin
            haz_s = 1'b0;
        end
    end

    // Input readiness: capacity check first, then gated by reset, flush and hazard.
    always_comb begin
        base_ready_s = 1'b0;
        if (USE_SKID) begin
            base_ready_s = !skid_valid_q;
        end else begin
            base_ready_s = !main_valid_q || out_ready_i;
        end
        in_ready_s = !rst_i && !flush_i && !haz_s && base_ready_s;
    end

    assign acc_s = in_valid_i && in_ready_s;
    assign iss_s = main_valid_q && out_ready_i;

    // Next-state for the main and skid entries. Flush overrides normal flow.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            main_d       = main_q & ~CTRL_MASK;
            skid_valid_d = 1'b0;
        end else if (USE_SKID) begin
            if (!main_valid_q || iss_s) begin
                // The main slot is free this cycle. The skid entry is older than the input, so it moves first.
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_d       = skid_q;
                    if (acc_s) begin
                        skid_valid_d = 1'b1;
                        skid_d       = in_ent_s;
                    end else begin
                        skid_valid_d = 1'b0;
                    end
                end else if (acc_s) begin
                    main_valid_d = 1'b1;
                    main_d       = in_ent_s;
                end else begin
                    main_valid_d = 1'b0;
                    main_d       = main_q & ~CTRL_MASK;
                end
            end else if (acc_s) begin
                skid_valid_d = 1'b1;
                skid_d       = in_ent_s;
            end else begin
                main_valid_d = main_valid_q;
            end
        end else begin
            if (acc_s) begin
                main_valid_d = 1'b1;
                main_d       = in_ent_s;
            end else if (iss_s) begin
                main_valid_d = 1'b0;
                main_d       = main_q & ~CTRL_MASK;
            end else begin
                main_valid_d = main_valid_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_q       <= {EW{1'b0}};
            skid_valid_q <= 1'b0;
            skid_q       <= {EW{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready_o       = in_ready_s;
    assign load_use_stall_o = !rst_i && haz_s;
    assign out_valid_o      = main_valid_q;
    assign out_data_o       = main_q[DA_LSB +: DATA_W];
    assign out_ctrl_o       = main_ctrl_s;
    assign out_waddr_o      = main_waddr_s;
    assign out_rs_o         = main_q[RS_LSB +: ASIZE];
    assign out_rt_o         = main_q[RT_LSB +: ASIZE];

endmodule

// File: tb/tb_id_exe_elastic_stage.sv
// Bench for id_exe_elastic_stage. It drives two instances at once:
// u_s1 is built with SKID=1 and u_s0 with SKID=0. The two instances share
// ctrl, tags, flush, reset and out_ready. Each instance has its own
// valid/data source.
// The reference model treats each stage as a bounded FIFO of
// instructions. The SKID=1 stage holds up to 2 entries. The SKID=0 stage
// holds 1 entry and can refill in the same cycle it issues.
module tb_id_exe_elastic_stage;

    typedef struct packed {
        logic [63:0] d;
        logic [6:0]  c;
        logic [3:0]  w;
        logic [3:0]  rs;
        logic [3:0]  rt;
    } ent_t;

    logic        clk, rst, flush, out_ready;
    logic        in_valid1, in_valid0;
    logic [63:0] in_data1, in_data0;
    logic [6:0]  in_ctrl;
    logic [3:0]  in_waddr, in_rs, in_rt;

    logic        rdy1, ov1, st1, rdy0, ov0, st0;
    logic [63:0] od1, od0;
    logic [6:0]  oc1, oc0;
    logic [3:0]  ow1, ors1, ort1, ow0, ors0, ort0;

    int total = 0;
    int bad   = 0;
    ent_t q1[$];
    ent_t q0[$];

    id_exe_elastic_stage #(.SKID(1)) u_s1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid1), .in_ready_o(rdy1), .in_data_i(in_data1),
        .in_ctrl_i(in_ctrl), .in_waddr_i(in_waddr), .in_rs_i(in_rs), .in_rt_i(in_rt),
        .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1), .out_ctrl_o(oc1),
        .out_waddr_o(ow1), .out_rs_o(ors1), .out_rt_o(ort1), .load_use_stall_o(st1)
    );

    id_exe_elastic_stage #(.SKID(0)) u_s0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid0), .in_ready_o(rdy0), .in_data_i(in_data0),
        .in_ctrl_i(in_ctrl), .in_waddr_i(in_waddr), .in_rs_i(in_rs), .in_rt_i(in_rt),
        .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0), .out_ctrl_o(oc0),
        .out_waddr_o(ow0), .out_rs_o(ors0), .out_rt_o(ort0), .load_use_stall_o(st0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hazard: the oldest held instruction is a load to a non-zero register that the presented instruction reads.
    function automatic bit m_haz(input int s);
        ent_t f;
        bit   v;
        v = (s != 0) ? in_valid1 : in_valid0;
        if ((s != 0) ? (q1.size() == 0) : (q0.size() == 0)) return 1'b0;
        f = (s != 0) ? q1[0] : q0[0];
        return v && f.c[4] && (f.w != 4'd0) && ((f.w == in_rs) || (f.w == in_rt));
    endfunction

    // The stage accepts input when it has room and no reset, flush or hazard is active.
    function automatic bit m_ready(input int s);
        if (rst || flush || m_haz(s)) return 1'b0;
        if (s != 0) return q1.size() < 2;
        return (q0.size() == 0) || out_ready;
    endfunction

    // Model update at each rising edge: EXE pops the head, a flush empties the FIFO, an accepted input is appended.
    always @(posedge clk) begin : model_upd
        bit a1, a0, i1, i0;
        a1 = in_valid1 && m_ready(1);
        a0 = in_valid0 && m_ready(0);
        i1 = (q1.size() > 0) && out_ready;
        i0 = (q0.size() > 0) && out_ready;
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            if (i1) void'(q1.pop_front());
            if (flush) q1.delete();
            else if (a1) q1.push_back({in_data1, in_ctrl, in_waddr, in_rs, in_rt});
            if (i0) void'(q0.pop_front());
            if (flush) q0.delete();
            else if (a0) q0.push_back({in_data0, in_ctrl, in_waddr, in_rs, in_rt});
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (rdy1 !== 1'b0 || rdy0 !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b%b exp=00", rdy1, rdy0); end
            total++; if (st1 !== 1'b0 || st0 !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b%b exp=00", st1, st0); end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        total++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", ov1, ov0); end
        total++; if (od1 !== 64'd0 || od0 !== 64'd0 || oc1 !== 7'd0 || oc0 !== 7'd0) begin bad++; $display("FAIL rst_data got=%h/%h ctrl=%h/%h exp=0", od1, od0, oc1, oc0); end
        total++; if ({ow1, ors1, ort1, ow0, ors0, ort0} !== 24'd0) begin bad++; $display("FAIL rst_tags got=%h exp=0", {ow1, ors1, ort1, ow0, ors0, ort0}); end
        total++; if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin bad++; $display("FAIL rst_idle_ready got=%b%b exp=11", rdy1, rdy0); end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; in_ctrl = 7'h03; in_waddr = 4'd1; in_rs = 4'd2; in_rt = 4'd3;
        for (int i = 0; i <= 9; i++) begin
            in_valid1 = (i < 8); in_valid0 = (i < 8);
            in_data1 = 64'(i + 1); in_data0 = 64'(i + 1);
            #1;
            if (i < 8) begin
                total++; if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b%b exp=11", i, rdy1, rdy0); end
            end
            if (i >= 1 && i <= 8) begin
                total++; if (ov1 !== 1'b1 || od1 !== 64'(i) || oc1 !== 7'h03) begin bad++; $display("FAIL stream_out1 i=%0d got=%b/%h/%h exp=1/%h/03", i, ov1, od1, oc1, i); end
                total++; if (ov0 !== 1'b1 || od0 !== 64'(i)) begin bad++; $display("FAIL stream_out0 i=%0d got=%b/%h exp=1/%h", i, ov0, od0, i); end
            end
            if (i == 9) begin
                total++; if (ov1 !== 1'b0 || oc1 !== 7'd0 || ov0 !== 1'b0 || oc0 !== 7'd0) begin bad++; $display("FAIL stream_drain got=%b%b ctrl=%h/%h exp=00/0", ov1, ov0, oc1, oc0); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit r1t [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit r0t [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bit vt  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int dt  [8] = '{0, 1, 1, 1, 2, 3, 4, 0};
        int idx1 = 0;
        int idx0 = 0;
        in_ctrl = 7'h01; in_waddr = 4'd2; in_rs = 4'd0; in_rt = 4'd0;
        for (int c = 0; c < 8; c++) begin
            out_ready = (c >= 3);
            in_valid1 = (idx1 < 4); in_data1 = 64'(idx1 + 1);
            in_valid0 = (idx0 < 4); in_data0 = 64'(idx0 + 1);
            #1;
            total++; if (rdy1 !== r1t[c]) begin bad++; $display("FAIL bp_ready1 c=%0d got=%b exp=%b", c, rdy1, r1t[c]); end
            total++; if (rdy0 !== r0t[c]) begin bad++; $display("FAIL bp_ready0 c=%0d got=%b exp=%b", c, rdy0, r0t[c]); end
            total++; if (ov1 !== vt[c] || ov0 !== vt[c]) begin bad++; $display("FAIL bp_valid c=%0d got=%b%b exp=%b", c, ov1, ov0, vt[c]); end
            if (vt[c]) begin
                total++; if (od1 !== 64'(dt[c]) || od0 !== 64'(dt[c])) begin bad++; $display("FAIL bp_data c=%0d got=%h/%h exp=%h", c, od1, od0, dt[c]); end
            end
            if (in_valid1 && r1t[c]) idx1++;
            if (in_valid0 && r0t[c]) idx0++;
            @(negedge clk);
        end
    endtask

    task automatic test_load_use(input logic [3:0] wa);
        bit exp_st;
        exp_st = (wa != 4'd0);
        out_ready = 1'b1;
        in_valid1 = 1'b1; in_valid0 = 1'b1; in_data1 = 64'h10; in_data0 = 64'h10;
        in_ctrl = 7'h10 | 7'h04; in_waddr = wa; in_rs = 4'd1; in_rt = 4'd2;
        @(negedge clk);
        in_data1 = 64'h11; in_data0 = 64'h11; in_ctrl = 7'h02; in_waddr = 4'd6; in_rs = wa; in_rt = 4'd0;
        #1;
        total++; if (st1 !== exp_st || st0 !== exp_st) begin bad++; $display("FAIL lu_stall wa=%0d got=%b%b exp=%b", wa, st1, st0, exp_st); end
        total++; if (rdy1 !== !exp_st || rdy0 !== !exp_st) begin bad++; $display("FAIL lu_ready wa=%0d got=%b%b exp=%b", wa, rdy1, rdy0, !exp_st); end
        total++; if (ov1 !== 1'b1 || od1 !== 64'h10 || ov0 !== 1'b1 || od0 !== 64'h10) begin bad++; $display("FAIL lu_load wa=%0d got=%h/%h", wa, od1, od0); end
        @(negedge clk);
        #1;
        if (exp_st) begin
            total++; if (ov1 !== 1'b0 || oc1 !== 7'd0 || ov0 !== 1'b0 || oc0 !== 7'd0) begin bad++; $display("FAIL lu_bubble got=%b%b ctrl=%h/%h exp=00/0", ov1, ov0, oc1, oc0); end
            total++; if (st1 !== 1'b0 || rdy1 !== 1'b1 || rdy0 !== 1'b1) begin bad++; $display("FAIL lu_release got=%b%b%b exp=011", st1, rdy1, rdy0); end
            @(negedge clk);
            #1;
        end
        in_valid1 = 1'b0; in_valid0 = 1'b0;
        total++; if (ov1 !== 1'b1 || od1 !== 64'h11 || ors1 !== wa || ov0 !== 1'b1 || od0 !== 64'h11) begin bad++; $display("FAIL lu_dep wa=%0d got=%b/%h/%0d exp=1/11/%0d", wa, ov1, od1, ors1, wa); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_ctrl = 7'h05; in_waddr = 4'd3; in_rs = 4'd0; in_rt = 4'd0;
        in_valid1 = 1'b1; in_valid0 = 1'b1; in_data1 = 64'hA; in_data0 = 64'hA;
        @(negedge clk);
        in_data1 = 64'hB; in_data0 = 64'hB;
        @(negedge clk);
        flush = 1'b1; in_data1 = 64'hC; in_data0 = 64'hC;
        #1;
        total++; if (rdy1 !== 1'b0 || rdy0 !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b%b exp=00", rdy1, rdy0); end
        total++; if (ov1 !== 1'b1 || od1 !== 64'hA) begin bad++; $display("FAIL flush_pre got=%b/%h exp=1/a", ov1, od1); end
        @(negedge clk);
        flush = 1'b0; in_valid1 = 1'b0; in_valid0 = 1'b0;
        #1;
        total++; if (ov1 !== 1'b0 || oc1 !== 7'd0 || ov0 !== 1'b0 || oc0 !== 7'd0) begin bad++; $display("FAIL flush_empty got=%b%b ctrl=%h/%h exp=00/0", ov1, ov0, oc1, oc0); end
        total++; if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin bad++; $display("FAIL flush_after_ready got=%b%b exp=11", rdy1, rdy0); end
        @(negedge clk);
        #1;
        total++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("FAIL flush_no_skid got=%b%b exp=00", ov1, ov0); end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid1 = ($urandom_range(0, 3) != 0);
            in_valid0 = ($urandom_range(0, 3) != 0);
            in_data1  = {$urandom, $urandom};
            in_data0  = {$urandom, $urandom};
            in_ctrl   = 7'($urandom);
            in_waddr  = 4'($urandom_range(0, 3));
            in_rs     = 4'($urandom_range(0, 3));
            in_rt     = 4'($urandom_range(0, 3));
            #1;
            total++; if (rdy1 !== m_ready(1) || st1 !== (!rst && m_haz(1))) begin bad++; $display("FAIL rnd_hs1 n=%0d got=%b%b exp=%b%b", n, rdy1, st1, m_ready(1), !rst && m_haz(1)); end
            total++; if (rdy0 !== m_ready(0) || st0 !== (!rst && m_haz(0))) begin bad++; $display("FAIL rnd_hs0 n=%0d got=%b%b exp=%b%b", n, rdy0, st0, m_ready(0), !rst && m_haz(0)); end
            total++; if (ov1 !== (q1.size() > 0)) begin bad++; $display("FAIL rnd_valid1 n=%0d got=%b exp=%b", n, ov1, q1.size() > 0); end
            total++; if (ov0 !== (q0.size() > 0)) begin bad++; $display("FAIL rnd_valid0 n=%0d got=%b exp=%b", n, ov0, q0.size() > 0); end
            if (q1.size() > 0) begin
                total++; if ({od1, oc1, ow1, ors1, ort1} !== q1[0]) begin bad++; $display("FAIL rnd_ent1 n=%0d got=%h exp=%h", n, {od1, oc1, ow1, ors1, ort1}, q1[0]); end
            end else begin
                total++; if (oc1 !== 7'd0) begin bad++; $display("FAIL rnd_bub1 n=%0d got=%h exp=0", n, oc1); end
            end
            if (q0.size() > 0) begin
                total++; if ({od0, oc0, ow0, ors0, ort0} !== q0[0]) begin bad++; $display("FAIL rnd_ent0 n=%0d got=%h exp=%h", n, {od0, oc0, ow0, ors0, ort0}, q0[0]); end
            end else begin
                total++; if (oc0 !== 7'd0) begin bad++; $display("FAIL rnd_bub0 n=%0d got=%h exp=0", n, oc0); end
            end
            @(negedge clk);
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_valid0 = 1'b0; in_data1 = 64'd0; in_data0 = 64'd0;
        in_ctrl = 7'd0; in_waddr = 4'd0; in_rs = 4'd0; in_rt = 4'd0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_load_use(4'd5);
        test_load_use(4'd0);
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
